mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Memory-stage consumer of the EX/MEM pipeline handshake. It is the downstream end of the execute stage's result/occupied/flush protocol.
- Accepts one EX/MEM entry while the execute stage holds it occupied, and returns a one-cycle flush so execute can free its register.
- Performs the load or store on the data-memory request/valid interface, then presents the MEM/WB entry to writeback and holds it until acknowledged.

Parameters:
- ADDR_W, 32, width of o_dmem_addr; taken from i_ex_result[ADDR_W-1:0].
- MEM_TIMEOUT, 15, maximum cycles a data-memory request waits for i_dmem_valid before it is aborted; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- i_ex_ready  in  1  EX/MEM register occupied (level, held until flushed)
- i_ex_result  in  32  ALU result; the memory address for loads and stores
- i_ex_store_data  in  32  store data (rs2 value)
- i_ex_mem_read  in  1  entry is a load
- i_ex_mem_write  in  1  entry is a store
- i_ex_rd  in  5  destination register
- o_ex_flush  out  1  one-cycle pulse; releases the EX/MEM register
- o_dmem_addr  out  ADDR_W  data-memory byte address
- o_dmem_wdata  out  32  store data
- o_dmem_re  out  1  read request, held until valid or timeout
- o_dmem_we  out  1  write request, held until valid or timeout
- i_dmem_rdata  in  32  read data, sampled when i_dmem_valid=1
- i_dmem_valid  in  1  memory completion strobe
- o_wb_valid  out  1  MEM/WB entry valid
- o_wb_rd  out  5  writeback register
- o_wb_data  out  32  writeback data
- i_wb_ack  in  1  writeback consumed the entry
- o_mem_err  out  1  sticky error flag; cleared only by reset
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; armed flag r_armed=1; timeout counter is 0.
- Arming: r_armed is cleared on capture and set on any clock edge where i_ex_ready=0. This prevents recapturing the same entry while execute is still dropping its occupied flag after the flush.
- States: IDLE, DISPATCH, MEM_REQ, WB_HOLD.
- IDLE:
  - On an edge with i_ex_ready=1 and r_armed=1, latch result, store data, mem_read, mem_write and rd, then go to DISPATCH.
  - Otherwise stay in IDLE.
- DISPATCH (exactly one cycle, o_ex_flush=1 here only):
  - If write, go to MEM_REQ with o_dmem_we=1.
  - Else if read, go to MEM_REQ with o_dmem_re=1.
  - Else (ALU op): load o_wb_data=result; if rd!=0 go to WB_HOLD, otherwise go to IDLE.
  - If both write and read are set, write wins, the read is ignored, and o_mem_err is set.
- MEM_REQ:
  - o_dmem_addr, o_dmem_wdata and the request bit stay stable for the whole state.
  - The counter increments each cycle in this state.
  - On i_dmem_valid=1: drop the request the next cycle.
    - Load with rd!=0: capture i_dmem_rdata into o_wb_data and go to WB_HOLD.
    - Store, or load with rd=0: go to IDLE.
  - If the counter reaches MEM_TIMEOUT without valid: drop the request, set o_mem_err, produce no writeback, go to IDLE.
  - If valid and timeout occur in the same cycle, valid wins.
- WB_HOLD:
  - o_wb_valid=1; o_wb_rd and o_wb_data are held.
  - On i_wb_ack=1, o_wb_valid falls the next cycle and the state goes to IDLE.
  - An ack arriving while o_wb_valid=0 is ignored.
- Latency from capture edge (cycle 0):
  - o_ex_flush is high in cycle 1.
  - For an ALU op, o_wb_valid rises in cycle 2.
  - For a load with zero-wait memory (valid in the first MEM_REQ cycle), o_wb_valid rises in cycle 3.
- i_dmem_valid outside MEM_REQ is ignored.
- Reset asserted mid-operation: everything returns to reset values immediately. The in-flight request and entry are discarded, and no flush pulse is emitted.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in DISPATCH, a load or store with result[1:0]!=0 is not issued. o_mem_err is set, no writeback occurs, and the state goes to IDLE; o_ex_flush still pulses.
- Undefined: the address is issued unchanged regardless of alignment, and the alignment check logic is absent.

Test Plan:
- ALU entry (i_ex_ready=1, result=0x0000002A, rd=5, no read/write):
  - o_ex_flush is a single pulse in cycle 1.
  - o_wb_valid=1 with rd=5, data=0x2A in cycle 2, held until i_wb_ack, then drops.
- Load (addr 0x100, rd=7), memory returns 0xDEADBEEF after 3 wait cycles:
  - o_dmem_re is held for 4 cycles.
  - Writeback shows rd=7, data=0xDEADBEEF; o_mem_err stays 0.
- Store (addr 0x104, data 0x12345678), i_dmem_valid never asserts:
  - o_dmem_we is high for exactly 15 cycles, then drops.
  - o_mem_err=1; o_wb_valid never rises; state returns to IDLE.
- i_ex_ready held high for 3 cycles after the flush, then low, then high again with new data:
  - Exactly two captures occur and exactly two flush pulses are produced.
- Load with rd=0 and ALU op with rd=0:
  - The memory access still happens for the load.
  - o_wb_valid stays 0 for both.
- rst driven low during MEM_REQ:
  - o_dmem_re and o_busy drop immediately; o_mem_err=0.
  - The next i_ex_ready entry is captured normally.
  - With MEM_ALIGN_CHECK_EN defined, a load at 0x102 sets o_mem_err and issues no request.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage consumer of the EX/MEM handshake. The block takes one entry
// while execute holds it occupied and pulses o_ex_flush for one cycle to free
// the execute register. It then runs the load or store on the data-memory
// request/valid interface. Finally it presents the MEM/WB entry and holds it
// until writeback acknowledges it.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   i_ex_*                    EX/MEM entry (ready level, result/address,
//                             store data, load/store flags, rd)
//   o_ex_flush                one-cycle release of the EX/MEM register
//   o_dmem_addr/wdata/re/we   data-memory request, held until valid/timeout
//   i_dmem_rdata/valid        data-memory completion
//   o_wb_valid/rd/data        MEM/WB entry, held until i_wb_ack
//   o_mem_err                 sticky error (timeout, read+write, misalign)
//   o_busy                    high whenever the FSM is not idle
//
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, a load or
// store whose address has result[1:0] != 0 is dropped in DISPATCH and flagged
// as an error.
module mem_stage_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ex_ready,
  input  logic [31:0]       i_ex_result,
  input  logic [31:0]       i_ex_store_data,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mem_write,
  input  logic [4:0]        i_ex_rd,
  output logic              o_ex_flush,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic              o_dmem_re,
  output logic              o_dmem_we,
  input  logic [31:0]       i_dmem_rdata,
  input  logic              i_dmem_valid,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [31:0]       o_wb_data,
  input  logic              i_wb_ack,
  output logic              o_mem_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    MEM_REQ  = 2'd2,
    WB_HOLD  = 2'd3
  } state_t;

  // The request has waited its full budget once the counter shows
  // MEM_TIMEOUT-1. The cycle that shows this value is the last one with the
  // request still high.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_n;
  logic        r_armed;
  logic [7:0]  r_cnt;
  logic        r_err;

  logic [31:0] ent_result_p0;
  logic [31:0] ent_sdata_p0;
  logic        ent_read_p0;
  logic        ent_write_p0;
  logic [4:0]  ent_rd_p0;
  logic [31:0] wb_data_p1;

  logic        capture;
  logic        wb_load_alu;
  logic        wb_load_mem;
  logic        err_set;
  logic        misalign;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (ent_read_p0 | ent_write_p0) && (ent_result_p0[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n     = state;
    capture     = 1'b0;
    wb_load_alu = 1'b0;
    wb_load_mem = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (i_ex_ready && r_armed) begin
          capture = 1'b1;
          state_n = DISPATCH;
        end
      end
      DISPATCH: begin
        if (misalign) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (ent_write_p0) begin
          // A store that also claims to be a load is treated as a store and
          // is flagged as an error.
          err_set = ent_read_p0;
          state_n = MEM_REQ;
        end else if (ent_read_p0) begin
          state_n = MEM_REQ;
        end else begin
          wb_load_alu = 1'b1;
          state_n     = (ent_rd_p0 != 5'd0) ? WB_HOLD : IDLE;
        end
      end
      MEM_REQ: begin
        // Completion has priority over a timeout in the same cycle.
        if (i_dmem_valid) begin
          if (!ent_write_p0 && (ent_rd_p0 != 5'd0)) begin
            wb_load_mem = 1'b1;
            state_n     = WB_HOLD;
          end else begin
            state_n = IDLE;
          end
        end else if (r_cnt == TO_LAST) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      WB_HOLD: begin
        if (i_wb_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_ex_flush = (state == DISPATCH);
    o_busy     = (state != IDLE);
    o_wb_valid = (state == WB_HOLD);
    o_dmem_we  = (state == MEM_REQ) && ent_write_p0;
    o_dmem_re  = (state == MEM_REQ) && ent_read_p0 && !ent_write_p0;
  end

  // Control: re-arm flag, wait counter, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= 1'b1;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      // Re-arm only after execute has dropped its occupied level. This keeps
      // the block from taking the same entry a second time after the flush.
      if (!i_ex_ready)  r_armed <= 1'b1;
      else if (capture) r_armed <= 1'b0;
      r_cnt <= (state == MEM_REQ) ? r_cnt + 8'd1 : 8'd0;
      if (err_set) r_err <= 1'b1;
    end
  end

  // Stage p0: captured EX/MEM entry
  // These registers drive output ports directly, so they are cleared on reset
  // to keep every output at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_result_p0 <= '0;
      ent_sdata_p0  <= '0;
      ent_read_p0   <= 1'b0;
      ent_write_p0  <= 1'b0;
      ent_rd_p0     <= '0;
    end else if (capture) begin
      ent_result_p0 <= i_ex_result;
      ent_sdata_p0  <= i_ex_store_data;
      ent_read_p0   <= i_ex_mem_read;
      ent_write_p0  <= i_ex_mem_write;
      ent_rd_p0     <= i_ex_rd;
    end
  end

  // Stage p1: MEM/WB data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             wb_data_p1 <= '0;
    else if (wb_load_alu) wb_data_p1 <= ent_result_p0;
    else if (wb_load_mem) wb_data_p1 <= i_dmem_rdata;
  end

  assign o_dmem_addr  = ent_result_p0[ADDR_W-1:0];
  assign o_dmem_wdata = ent_sdata_p0;
  assign o_wb_rd      = ent_rd_p0;
  assign o_wb_data    = wb_data_p1;
  assign o_mem_err    = r_err;

endmodule
